// File: rtl/led_pkg.sv
// Shared definitions for the LED breathing block and its upstream tick counter:
// FSM state encodings, default widths and a hold-counter helper.
package led_pkg;

    localparam int LED_PWM_BITS   = 8;
    localparam int LED_DUTY_STEP  = 1;
    localparam int LED_HOLD_TICKS = 4;
    localparam int LED_HOLD_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } led_state_t;

    function automatic logic [LED_HOLD_W-1:0] hold_next(input logic [LED_HOLD_W-1:0] cnt);
        return cnt + 8'd1;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter, comparator and period-boundary duty register.
// New duty values take effect only when the counter wraps, so the LED never glitches.
module led_pwm_gen
    import led_pkg::*;
#(
    parameter int PWM_BITS = LED_PWM_BITS
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                clr,
    input  logic [PWM_BITS-1:0] duty_map,
    output logic                led_out,
    output logic [PWM_BITS-1:0] duty_act,
    output logic                period_end
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] CNT_PRE = CNT_MAX - PWM_BITS'(1);

    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] duty_act_r;
    logic                led_out_r;
    logic                period_end_r;

    // Counter, boundary flag (pre-decoded so it is high while the counter sits at max), duty load and pin drive.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_r    <= '0;
            period_end_r <= 1'b0;
            duty_act_r   <= '0;
            led_out_r    <= 1'b0;
        end else begin
            pwm_cnt_r    <= pwm_cnt_r + PWM_BITS'(1);
            period_end_r <= (pwm_cnt_r == CNT_PRE);
            if (clr) begin
                duty_act_r <= '0;
                led_out_r  <= 1'b0;
            end else begin
                led_out_r <= (pwm_cnt_r < duty_act_r);
                if (period_end_r) begin
                    duty_act_r <= duty_map;
                end else begin
                    duty_act_r <= duty_act_r;
                end
            end
        end
    end

    assign led_out    = led_out_r;
    assign duty_act   = duty_act_r;
    assign period_end = period_end_r;

endmodule

// File: rtl/led_breath.sv
// LED breathing controller: tick-driven rise/hold/fall/hold duty ramp feeding a PWM generator.
// Optional perceptual (squared) duty mapping is enabled by defining LED_BREATH_GAMMA_EN.
module led_breath
    import led_pkg::*;
#(
    parameter int PWM_BITS   = LED_PWM_BITS,
    parameter int DUTY_STEP  = LED_DUTY_STEP,
    parameter int HOLD_TICKS = LED_HOLD_TICKS
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                tick_in,
    input  logic                en,
    output logic                led_out,
    output logic [PWM_BITS-1:0] duty_o,
    output logic [2:0]          state_o,
    output logic                period_end_o
);

    localparam logic [PWM_BITS:0]   MAX_W  = {1'b0, {PWM_BITS{1'b1}}};
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(DUTY_STEP);
    localparam logic [LED_HOLD_W-1:0] HOLD_W = LED_HOLD_W'(HOLD_TICKS);

    led_state_t              state_r;
    logic [PWM_BITS-1:0]     duty_tgt_r;
    logic [LED_HOLD_W-1:0]   hold_cnt_r;
    logic [LED_HOLD_W-1:0]   hold_nxt_s;
    logic [PWM_BITS:0]       up_s;
    logic [PWM_BITS:0]       dn_s;
    logic [PWM_BITS-1:0]     duty_map_s;

    // One extra bit on the ramp arithmetic exposes overflow/borrow for saturation.
    always_comb begin
        up_s       = {1'b0, duty_tgt_r} + STEP_W;
        dn_s       = {1'b0, duty_tgt_r} - STEP_W;
        hold_nxt_s = hold_next(hold_cnt_r);
    end

`ifdef LED_BREATH_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq_s;

    // Squared ramp approximates perceived brightness.
    always_comb begin
        sq_s       = {{PWM_BITS{1'b0}}, duty_tgt_r} * {{PWM_BITS{1'b0}}, duty_tgt_r};
        duty_map_s = PWM_BITS'(sq_s >> PWM_BITS);
    end
`else
    // Linear ramp: target duty drives the comparator directly.
    always_comb begin
        duty_map_s = duty_tgt_r;
    end
`endif

    // Breathing FSM; a low enable overrides everything, including a coincident tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            duty_tgt_r <= '0;
            hold_cnt_r <= '0;
        end else if (!en) begin
            state_r    <= ST_IDLE;
            duty_tgt_r <= '0;
            hold_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    duty_tgt_r <= '0;
                    state_r    <= ST_RISE;
                end
                ST_RISE: begin
                    if (tick_in) begin
                        if (up_s >= MAX_W) begin
                            duty_tgt_r <= MAX_W[PWM_BITS-1:0];
                            hold_cnt_r <= '0;
                            state_r    <= ST_HOLD_HI;
                        end else begin
                            duty_tgt_r <= up_s[PWM_BITS-1:0];
                        end
                    end else begin
                        duty_tgt_r <= duty_tgt_r;
                    end
                end
                ST_HOLD_HI, ST_HOLD_LO: begin
                    if (tick_in) begin
                        hold_cnt_r <= hold_nxt_s;
                        if (hold_nxt_s == HOLD_W) begin
                            state_r <= (state_r == ST_HOLD_HI) ? ST_FALL : ST_RISE;
                        end else begin
                            state_r <= state_r;
                        end
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                ST_FALL: begin
                    if (tick_in) begin
                        if (dn_s[PWM_BITS] || (dn_s == '0)) begin
                            duty_tgt_r <= '0;
                            hold_cnt_r <= '0;
                            state_r    <= ST_HOLD_LO;
                        end else begin
                            duty_tgt_r <= dn_s[PWM_BITS-1:0];
                        end
                    end else begin
                        duty_tgt_r <= duty_tgt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    duty_tgt_r <= '0;
                    hold_cnt_r <= '0;
                end
            endcase
        end
    end

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .clr        (~en),
        .duty_map   (duty_map_s),
        .led_out    (led_out),
        .duty_act   (duty_o),
        .period_end (period_end_o)
    );

    assign state_o = state_r;

endmodule

// File: tb/tb_led_breath.sv
// Self-checking bench for led_breath (PWM_BITS=4, DUTY_STEP=4, HOLD_TICKS=2) with a behavioural model.
module tb_led_breath;

    localparam int PB   = 4;
    localparam int STEP = 4;
    localparam int HOLD = 2;
    localparam int MAXD = 15;
    localparam int PER  = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       en = 1'b0;
    logic       led_out;
    logic [3:0] duty_o;
    logic [2:0] state_o;
    logic       period_end_o;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model: 0 IDLE, 1 RISE, 2 HOLD_HI, 3 FALL, 4 HOLD_LO
    int m_cnt, m_act, m_tgt, m_hold, m_state;
    bit m_led, m_pe;

    always #5 sys_clk = ~sys_clk;

    led_breath #(.PWM_BITS(PB), .DUTY_STEP(STEP), .HOLD_TICKS(HOLD)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .tick_in      (tick_in),
        .en           (en),
        .led_out      (led_out),
        .duty_o       (duty_o),
        .state_o      (state_o),
        .period_end_o (period_end_o)
    );

    function automatic int map_duty(input int d);
`ifdef LED_BREATH_GAMMA_EN
        return (d * d) / PER;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_act = 0; m_tgt = 0; m_hold = 0; m_state = 0; m_led = 0; m_pe = 0;
    endtask

    task automatic model_edge(input bit e, input bit t);
        int ncnt;
        ncnt  = (m_cnt + 1) % PER;
        m_led = e && (m_cnt < m_act);
        if (!e) m_act = 0;
        else if (m_cnt == PER - 1) m_act = map_duty(m_tgt);
        if (!e) begin
            m_state = 0; m_tgt = 0; m_hold = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_tgt = 0;
        end else if (t) begin
            if (m_state == 1) begin
                m_tgt = (m_tgt + STEP > MAXD) ? MAXD : m_tgt + STEP;
                if (m_tgt == MAXD) begin m_state = 2; m_hold = 0; end
            end else if (m_state == 3) begin
                m_tgt = (m_tgt - STEP < 0) ? 0 : m_tgt - STEP;
                if (m_tgt == 0) begin m_state = 4; m_hold = 0; end
            end else begin
                m_hold = m_hold + 1;
                if (m_hold == HOLD) m_state = (m_state == 2) ? 3 : 1;
            end
        end
        m_cnt = ncnt;
        m_pe  = (m_cnt == PER - 1);
    endtask

    task automatic step(input bit e, input bit t);
        en = e;
        tick_in = t;
        @(posedge sys_clk);
        model_edge(e, t);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge sys_clk);
        sys_rst_n = 1'b0; en = 1'b0; tick_in = 1'b0;
        #2;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #12;
        n_checks++;
        if (state_o !== 3'd0 || duty_o !== 4'd0 || led_out !== 1'b0 || period_end_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: state=%0d duty=%0d led=%0b pe=%0b, expected all 0", state_o, duty_o, led_out, period_end_o);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_rise_no_tick();
        step(1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (state_o !== 3'd1 || duty_o !== 4'd0 || led_out !== 1'b0) begin
                n_errors++;
                $display("FAIL rise_no_tick[%0d]: state=%0d duty=%0d led=%0b, expected 1/0/0", i, state_o, duty_o, led_out);
            end
        end
    endtask

    task automatic test_ramp();
        logic [3:0] prev_duty;
        logic       prev_pe;
        int         exp_tgt;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 20; c++) begin
                prev_duty = duty_o;
                prev_pe   = period_end_o;
                step(1'b1, c == 0);
                n_checks++;
                if (duty_o !== prev_duty && prev_pe !== 1'b1) begin
                    n_errors++;
                    $display("FAIL ramp_boundary: duty %0d -> %0d outside period boundary", prev_duty, duty_o);
                end
            end
            exp_tgt = (STEP * (k + 1) > MAXD) ? MAXD : STEP * (k + 1);
            n_checks++;
            if (duty_o !== 4'(map_duty(exp_tgt))) begin
                n_errors++;
                $display("FAIL ramp_duty[%0d]: duty=%0d expected %0d", k, duty_o, map_duty(exp_tgt));
            end
        end
        n_checks++;
        if (state_o !== 3'd2) begin
            n_errors++;
            $display("FAIL ramp_state: state=%0d expected 2", state_o);
        end
    endtask

    task automatic test_duty8();
        int highs;
        int guard;
        bit exp_led;
        reset_dut();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        guard = 0;
        do begin
            step(1'b1, 1'b0);
            guard++;
        end while (period_end_o !== 1'b1 && guard < 40);
        n_checks++;
        if (period_end_o !== 1'b1) begin
            n_errors++;
            $display("FAIL duty8_wait: pe=%0b expected 1 within 40 cycles", period_end_o);
        end
        step(1'b1, 1'b0);
        highs = 0;
        for (int j = 1; j <= PER; j++) begin
            step(1'b1, 1'b0);
            exp_led = (j <= map_duty(8));
            if (led_out === 1'b1) highs++;
            n_checks++;
            if (led_out !== exp_led) begin
                n_errors++;
                $display("FAIL duty8_led[%0d]: led=%0b expected %0b", j, led_out, exp_led);
            end
        end
        n_checks++;
        if (highs != map_duty(8)) begin
            n_errors++;
            $display("FAIL duty8_count: high=%0d expected %0d", highs, map_duty(8));
        end
    endtask

    task automatic test_full_cycle();
        int exp_st[12] = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 4, 4, 1};
        reset_dut();
        step(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1);
            n_checks++;
            if (state_o !== 3'(exp_st[i])) begin
                n_errors++;
                $display("FAIL full_cycle[%0d]: state=%0d expected %0d", i, state_o, exp_st[i]);
            end
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
        end
    endtask

    task automatic test_en_drop();
        int guard;
        reset_dut();
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        guard = 0;
        while (duty_o !== 4'(map_duty(12)) && guard < 40) begin
            step(1'b1, 1'b0);
            guard++;
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (state_o !== 3'd0 || duty_o !== 4'd0 || led_out !== 1'b0) begin
            n_errors++;
            $display("FAIL en_drop: state=%0d duty=%0d led=%0b, expected 0/0/0", state_o, duty_o, led_out);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        n_checks++;
        if (duty_o !== 4'd0 || state_o !== 3'd1) begin
            n_errors++;
            $display("FAIL en_drop_tick_lost: duty=%0d state=%0d, expected 0/1", duty_o, state_o);
        end
    endtask

    task automatic test_boundary_tick();
        int guard;
        reset_dut();
        step(1'b1, 1'b0);
        guard = 0;
        do begin
            step(1'b1, 1'b0);
            guard++;
        end while (period_end_o !== 1'b1 && guard < 40);
        step(1'b1, 1'b1);
        n_checks++;
        if (duty_o !== 4'd0) begin
            n_errors++;
            $display("FAIL boundary_tick_old: duty=%0d expected 0", duty_o);
        end
        for (int i = 0; i < PER; i++) step(1'b1, 1'b0);
        n_checks++;
        if (duty_o !== 4'(map_duty(STEP))) begin
            n_errors++;
            $display("FAIL boundary_tick_new: duty=%0d expected %0d", duty_o, map_duty(STEP));
        end
    endtask

    task automatic test_gamma();
        logic [3:0] exp_d;
`ifdef LED_BREATH_GAMMA_EN
        exp_d = 4'd9;
`else
        exp_d = 4'd12;
`endif
        reset_dut();
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        n_checks++;
        if (duty_o !== exp_d) begin
            n_errors++;
            $display("FAIL gamma_map: duty=%0d expected %0d", duty_o, exp_d);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        step(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        @(negedge sys_clk);
        #1 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 3'd0 || duty_o !== 4'd0 || led_out !== 1'b0 || period_end_o !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: state=%0d duty=%0d led=%0b pe=%0b, expected all 0", state_o, duty_o, led_out, period_end_o);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0);
        n_checks++;
        if (state_o !== 3'd1 || duty_o !== 4'd0) begin
            n_errors++;
            $display("FAIL async_reset_restart: state=%0d duty=%0d, expected 1/0", state_o, duty_o);
        end
    endtask

    task automatic test_random();
        bit e, t;
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            e = ($urandom_range(0, 99) >= 3);
            t = ($urandom_range(0, 5) == 0);
            step(e, t);
            n_checks++;
            if (state_o !== 3'(m_state) || duty_o !== 4'(m_act) || led_out !== m_led || period_end_o !== m_pe) begin
                n_errors++;
                $display("FAIL random[%0d]: state=%0d duty=%0d led=%0b pe=%0b expected %0d/%0d/%0b/%0b",
                         i, state_o, duty_o, led_out, period_end_o, m_state, m_act, m_led, m_pe);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rise_no_tick();
        test_ramp();
        test_duty8();
        test_full_cycle();
        test_en_drop();
        test_boundary_tick();
        test_gamma();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
